// File: rtl/n64_read_prefetch.sv
// Read-ahead buffer between the N64 PI bus master and the arbiter n64 port.
// Read misses are fetched on demand, then sequential words are prefetched into
// a small FIFO so that following burst reads hit with one cycle of latency.
// Writes and out-of-sequence reads pass through and discard the buffer.
module n64_read_prefetch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        up_request,
    output logic        up_ack,
    input  logic        up_write,
    input  logic [31:0] up_address,
    input  logic [15:0] up_wdata,
    input  logic [1:0]  up_wmask,
    output logic [15:0] up_rdata,
    output logic        dn_request,
    input  logic        dn_ack,
    output logic        dn_write,
    output logic [31:0] dn_address,
    output logic [15:0] dn_wdata,
    output logic [1:0]  dn_wmask,
    input  logic [15:0] dn_rdata
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StDemand,
        StWrite,
        StPrefetch
    } state_e;

    state_e            state_q;
    logic [15:0]       fifo_mem [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW:0]     count_q;
    logic [31:0]       next_addr_q;
    logic              pf_valid_q;
    logic              stale_q;

    logic              up_new;
    logic [30:0]       head_word;
    logic              hit;
    logic              pass_through;
    logic              push;
    logic              pf_start;
    logic              clear;

    // Byte lane select is irrelevant for 16-bit word addressing.
    logic              unused_addr_bit;
    assign unused_addr_bit = up_address[0];

    // Hit/miss decode and FIFO control; up_ack masks the still-held request of an acked transfer.
    always_comb begin
        up_new       = up_request & ~up_ack;
        // Buffered words are contiguous and end just below next_addr.
        head_word    = next_addr_q[31:1] - {{(30 - PtrW){1'b0}}, count_q};
        hit          = (state_q == StIdle) && up_new && !up_write && !flush &&
                       (count_q != '0) && (up_address[31:1] == head_word);
        pass_through = (state_q == StIdle) && up_new && !hit;
        push         = (state_q == StPrefetch) && dn_ack && !stale_q && !flush;
        // Prefetch only while the upstream side is quiet, so back-to-back hits are not stalled.
        pf_start     = (state_q == StIdle) && !up_request && !up_ack && pf_valid_q && !flush &&
                       (count_q < FullCount) && (next_addr_q[15:0] != 16'h0000);
        clear        = flush || pass_through;
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dn_rdata;
        end
    end

    // Control FSM, FIFO pointers and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            next_addr_q <= '0;
            pf_valid_q  <= 1'b0;
            stale_q     <= 1'b0;
            up_ack      <= 1'b0;
            up_rdata    <= '0;
            dn_request  <= 1'b0;
            dn_write    <= 1'b0;
            dn_address  <= '0;
            dn_wdata    <= '0;
            dn_wmask    <= '0;
        end else begin
            up_ack <= 1'b0;

            if (clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
                count_q  <= count_q + (PtrW + 1)'(1);
            end else if (hit) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                count_q  <= count_q - (PtrW + 1)'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        up_ack   <= 1'b1;
                        up_rdata <= fifo_mem[rd_ptr_q];
                    end else if (pass_through && up_write) begin
                        state_q    <= StWrite;
                        pf_valid_q <= 1'b0;
                        dn_request <= 1'b1;
                        dn_write   <= 1'b1;
                        dn_address <= {up_address[31:1], 1'b0};
                        dn_wdata   <= up_wdata;
                        dn_wmask   <= up_wmask;
                    end else if (pass_through) begin
                        state_q     <= StDemand;
                        pf_valid_q  <= 1'b1;
                        next_addr_q <= {up_address[31:1], 1'b0} + 32'd2;
                        dn_request  <= 1'b1;
                        dn_write    <= 1'b0;
                        dn_address  <= {up_address[31:1], 1'b0};
                    end else if (pf_start) begin
                        state_q    <= StPrefetch;
                        dn_request <= 1'b1;
                        dn_write   <= 1'b0;
                        dn_address <= next_addr_q;
                    end
                end
                StDemand: begin
                    if (dn_ack) begin
                        state_q    <= StIdle;
                        dn_request <= 1'b0;
                        up_ack     <= 1'b1;
                        up_rdata   <= dn_rdata;
                    end
                end
                StWrite: begin
                    if (dn_ack) begin
                        state_q    <= StIdle;
                        dn_request <= 1'b0;
                        up_ack     <= 1'b1;
                    end
                end
                StPrefetch: begin
                    // A flushed prefetch still runs to completion, but its data is dropped.
                    if (flush) begin
                        stale_q <= 1'b1;
                    end
                    if (dn_ack) begin
                        state_q    <= StIdle;
                        dn_request <= 1'b0;
                        stale_q    <= 1'b0;
                        if (push) begin
                            next_addr_q <= next_addr_q + 32'd2;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (flush) begin
                pf_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_n64_read_prefetch.sv
// Self-checking bench for n64_read_prefetch: a downstream memory model with random
// latency, an upstream read-data scoreboard, and directed burst/miss/flush/reset scenarios.
module tb_n64_read_prefetch;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        up_request;
    logic        up_ack;
    logic        up_write;
    logic [31:0] up_address;
    logic [15:0] up_wdata;
    logic [1:0]  up_wmask;
    logic [15:0] up_rdata;
    logic        dn_request;
    logic        dn_ack;
    logic        dn_write;
    logic [31:0] dn_address;
    logic [15:0] dn_wdata;
    logic [1:0]  dn_wmask;
    logic [15:0] dn_rdata;

    int          vectors;
    int          miscompares;
    int          cyc;
    int          dn_ack_cyc;
    logic [16:0] exp_q [$];
    logic [31:0] log_addr [$];
    logic        log_wr [$];
    logic [15:0] log_wdata [$];
    logic [1:0]  log_wmask [$];
    logic        flush_arm;
    logic [31:0] flush_addr;

    n64_read_prefetch #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .up_request (up_request),
        .up_ack     (up_ack),
        .up_write   (up_write),
        .up_address (up_address),
        .up_wdata   (up_wdata),
        .up_wmask   (up_wmask),
        .up_rdata   (up_rdata),
        .dn_request (dn_request),
        .dn_ack     (dn_ack),
        .dn_write   (dn_write),
        .dn_address (dn_address),
        .dn_wdata   (dn_wdata),
        .dn_wmask   (dn_wmask),
        .dn_rdata   (dn_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_model(input logic [31:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        if (i >= 0 && i < log_addr.size()) return log_addr[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Downstream memory: random latency, logs every transaction, optional flush on a chosen ack.
    initial begin
        int          wait_left;
        logic        busy;
        logic [31:0] st_addr;
        dn_ack    = 1'b0;
        dn_rdata  = '0;
        flush     = 1'b0;
        busy      = 1'b0;
        wait_left = 0;
        st_addr   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dn_ack = 1'b0;
                flush  = 1'b0;
                busy   = 1'b0;
            end else if (dn_ack) begin
                dn_ack = 1'b0;
                flush  = 1'b0;
                check("dn_req_drop", 32'(dn_request), 32'd0);
            end else if (dn_request) begin
                if (!busy) begin
                    busy      = 1'b1;
                    wait_left = int'($urandom_range(0, 3));
                    st_addr   = dn_address;
                    log_addr.push_back(dn_address);
                    log_wr.push_back(dn_write);
                    log_wdata.push_back(dn_wdata);
                    log_wmask.push_back(dn_wmask);
                end
                if (wait_left == 0) begin
                    check("dn_addr_stable", dn_address, st_addr);
                    busy       = 1'b0;
                    dn_ack     = 1'b1;
                    dn_ack_cyc = cyc;
                    dn_rdata   = dn_write ? 16'h0000 : mem_model(dn_address);
                    if (flush_arm && !dn_write && dn_address == flush_addr) begin
                        flush     = 1'b1;
                        flush_arm = 1'b0;
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Upstream scoreboard: every ack retires the oldest outstanding request.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset_n && up_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (!e[16]) check("sb_rdata", 32'(up_rdata), 32'(e[15:0]));
            end
        end
    end

    task automatic up_xfer(input logic wr, input logic [31:0] a, input logic [15:0] d,
                           input logic [1:0] m, output int lat, output int ack_cyc,
                           output logic [15:0] rd);
        @(negedge clk);
        up_request = 1'b1;
        up_write   = wr;
        up_address = a;
        up_wdata   = d;
        up_wmask   = m;
        exp_q.push_back({wr, wr ? 16'h0000 : mem_model(a)});
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!up_ack && lat < 200);
        check("up_ack_timeout", 32'(up_ack), 32'd1);
        ack_cyc = cyc;
        rd      = up_rdata;
        @(negedge clk);
        up_request = 1'b0;
        up_write   = 1'b0;
    endtask

    initial begin
        int          lat;
        int          ack_cyc;
        int          n;
        logic [15:0] rd;
        logic [31:0] a;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        dn_ack_cyc  = 0;
        flush_arm   = 1'b0;
        flush_addr  = '0;
        reset_n     = 1'b0;
        up_request  = 1'b0;
        up_write    = 1'b0;
        up_address  = '0;
        up_wdata    = '0;
        up_wmask    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_up_ack", 32'(up_ack), 32'd0);
        check("rst_up_rdata", 32'(up_rdata), 32'd0);
        check("rst_dn_request", 32'(dn_request), 32'd0);
        check("rst_dn_write", 32'(dn_write), 32'd0);
        check("rst_dn_address", dn_address, 32'd0);
        check("rst_dn_wdata", 32'(dn_wdata), 32'd0);
        check("rst_dn_wmask", 32'(dn_wmask), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Demand miss then sequential fill to DEPTH words.
        n = log_addr.size();
        up_xfer(1'b0, 32'h1000_0000, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t1_rdata", 32'(rd), 32'h0000_A5A5);
        check("t1_ack_after_dn", 32'(ack_cyc), 32'(dn_ack_cyc + 1));
        check("t1_dn_addr", addr_at(n), 32'h1000_0000);
        repeat (40) @(negedge clk);
        check("t1_dn_count", 32'(log_addr.size()), 32'(n + 5));
        for (int i = 1; i <= 4; i++) begin
            check("t1_pf_addr", addr_at(n + i), 32'h1000_0000 + 32'(2 * i));
        end

        // Buffered hits: one cycle latency, no downstream traffic.
        n = log_addr.size();
        for (int i = 1; i <= 3; i++) begin
            a = 32'h1000_0000 + 32'(2 * i);
            up_xfer(1'b0, a, 16'h0, 2'b00, lat, ack_cyc, rd);
            check("t2_hit_lat", 32'(lat), 32'd1);
            check("t2_hit_data", 32'(rd), 32'(mem_model(a)));
        end
        check("t2_no_dn", 32'(log_addr.size()), 32'(n));
        repeat (40) @(negedge clk);

        // Out-of-sequence read with full buffer: miss and refill from the new address.
        n = log_addr.size();
        up_xfer(1'b0, 32'h1000_0040, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t3_rdata", 32'(rd), 32'(mem_model(32'h1000_0040)));
        check("t3_ack_after_dn", 32'(ack_cyc), 32'(dn_ack_cyc + 1));
        check("t3_dn_addr", addr_at(n), 32'h1000_0040);
        repeat (40) @(negedge clk);
        check("t3_dn_count", 32'(log_addr.size()), 32'(n + 5));
        for (int i = 1; i <= 4; i++) begin
            check("t3_pf_addr", addr_at(n + i), 32'h1000_0040 + 32'(2 * i));
        end
        up_xfer(1'b0, 32'h1000_0042, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t3_hit_lat", 32'(lat), 32'd1);

        // Write while a prefetch is in flight.
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dn_request && lat < 50);
        check("t4_pf_inflight", 32'(dn_request), 32'd1);
        up_xfer(1'b1, 32'h1000_0004, 16'h1234, 2'b11, lat, ack_cyc, rd);
        n = log_addr.size();
        check("t4_ack_after_dn", 32'(ack_cyc), 32'(dn_ack_cyc + 1));
        check("t4_pf_before", addr_at(n - 2), 32'h1000_004A);
        check("t4_wr_addr", addr_at(n - 1), 32'h1000_0004);
        check("t4_wr_flag", 32'(log_wr[n - 1]), 32'd1);
        check("t4_wr_data", 32'(log_wdata[n - 1]), 32'h0000_1234);
        check("t4_wr_mask", 32'(log_wmask[n - 1]), 32'd3);
        repeat (30) @(negedge clk);
        check("t4_no_pf", 32'(log_addr.size()), 32'(n));
        up_xfer(1'b0, 32'h1000_0044, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t4_discarded_miss", 32'(log_addr.size()), 32'(n + 1));
        check("t4_rdata", 32'(rd), 32'(mem_model(32'h1000_0044)));
        repeat (40) @(negedge clk);

        // Flush coincident with a prefetch ack.
        flush_addr = 32'h2000_0002;
        flush_arm  = 1'b1;
        n = log_addr.size();
        up_xfer(1'b0, 32'h2000_0000, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t5_rdata", 32'(rd), 32'(mem_model(32'h2000_0000)));
        repeat (40) @(negedge clk);
        check("t5_flush_fired", 32'(flush_arm), 32'd0);
        check("t5_dn_count", 32'(log_addr.size()), 32'(n + 2));
        check("t5_pf_addr", addr_at(n + 1), 32'h2000_0002);
        n = log_addr.size();
        up_xfer(1'b0, 32'h2000_0002, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t5_miss", 32'(log_addr.size()), 32'(n + 1));
        check("t5_miss_addr", addr_at(n), 32'h2000_0002);
        check("t5_rdata2", 32'(rd), 32'(mem_model(32'h2000_0002)));
        repeat (40) @(negedge clk);

        // Reset during a demand fetch, then a read at the top of a 64 KiB page.
        @(negedge clk);
        up_request = 1'b1;
        up_write   = 1'b0;
        up_address = 32'h3000_0000;
        exp_q.push_back({1'b0, mem_model(32'h3000_0000)});
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dn_request && lat < 20);
        check("t6_demand_issued", 32'(dn_request), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_dn_request", 32'(dn_request), 32'd0);
        check("t6_rst_up_ack", 32'(up_ack), 32'd0);
        check("t6_rst_dn_address", dn_address, 32'd0);
        up_request = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        n = log_addr.size();
        up_xfer(1'b0, 32'h0000_FFFE, 16'h0, 2'b00, lat, ack_cyc, rd);
        check("t6_miss_addr", addr_at(n), 32'h0000_FFFE);
        check("t6_rdata", 32'(rd), 32'(mem_model(32'h0000_FFFE)));
        repeat (30) @(negedge clk);
        check("t6_no_cross", 32'(log_addr.size()), 32'(n + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
